// File: rtl/rv32_hazard_pkg.sv
// Shared encodings and widths for the rv32i execute-stage hazard scheduler.
package rv32_hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 8;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH     = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_ALU = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // Operand source select; the youngest producing stage wins, x0 never forwards.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  used,
        input logic                  alu_hit,
        input logic                  mem_hit,
        input logic                  wb_hit
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (!used || rs == '0) sel = FWD_RF;
        else if (alu_hit)      sel = FWD_ALU;
        else if (mem_hit)      sel = FWD_MEM;
        else if (wb_hit)       sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_scheduler_load_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, set wins over clear.
module load_scoreboard
    import rv32_hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic                  clr_all,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic                  hit_a_c,
    output logic                  hit_b_c
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_all)     pending_d = '0;
        else if (clr_en) pending_d[clr_addr] = 1'b0;
        if (set_en)      pending_d[set_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    // A load returning this cycle already releases its dependents.
    assign hit_a_c = pending_q[rd_addr_a] && !(clr_en && clr_addr == rd_addr_a);
    assign hit_b_c = pending_q[rd_addr_b] && !(clr_en && clr_addr == rd_addr_b);

endmodule

// File: rtl/hazard_scheduler.sv
// Execute-stage sequencing: load-use stall FSM, redirect flush timer, operand forwarding.
// Optional saturating performance counters under `define HAZARD_PERF_CNT_EN.
module hazard_scheduler
    import rv32_hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned LOAD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_de_ce,
    input  logic [REG_ADDR_W-1:0] i_de_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_de_rs2_addr,
    input  logic                  i_de_rs1_used,
    input  logic                  i_de_rs2_used,
    input  logic                  i_alu_ce,
    input  logic [REG_ADDR_W-1:0] i_alu_rd_addr,
    input  logic                  i_alu_wr,
    input  logic                  i_alu_is_load,
    input  logic                  i_alu_change_pc,
    input  logic                  i_mem_ce,
    input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
    input  logic                  i_mem_wr,
    input  logic                  i_mem_load_done,
    input  logic [REG_ADDR_W-1:0] i_mem_load_rd,
    input  logic                  i_wb_we,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    output logic                  o_force_stall,
    output logic                  o_flush,
    output logic [1:0]            o_fwd_rs1,
    output logic [1:0]            o_fwd_rs2,
    output logic [1:0]            o_state,
    output logic                  o_load_timeout,
    output logic [31:0]           o_stall_cycles,
    output logic [31:0]           o_flush_events
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             sb_clear_all;
    logic             sb_set;
    logic             sb_hit1, sb_hit2;
    logic             alu_fwd_ok;
    logic             alu_load;
    logic             haz_rs1, haz_rs2, hazard;

    assign sb_set = i_alu_ce && i_alu_is_load && i_alu_wr && (i_alu_rd_addr != '0);

    load_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (sb_set),
        .set_addr  (i_alu_rd_addr),
        .clr_en    (i_mem_load_done),
        .clr_addr  (i_mem_load_rd),
        .clr_all   (sb_clear_all),
        .rd_addr_a (i_de_rs1_addr),
        .rd_addr_b (i_de_rs2_addr),
        .hit_a_c   (sb_hit1),
        .hit_b_c   (sb_hit2)
    );

    // Forwarding: load results are not available from the ALU stage.
    assign alu_fwd_ok = i_alu_ce && i_alu_wr && !i_alu_is_load;
    assign o_fwd_rs1 = fwd_select(i_de_rs1_addr, i_de_rs1_used,
                                  alu_fwd_ok && (i_alu_rd_addr == i_de_rs1_addr),
                                  i_mem_ce && i_mem_wr && (i_mem_rd_addr == i_de_rs1_addr),
                                  i_wb_we && (i_wb_rd_addr == i_de_rs1_addr));
    assign o_fwd_rs2 = fwd_select(i_de_rs2_addr, i_de_rs2_used,
                                  alu_fwd_ok && (i_alu_rd_addr == i_de_rs2_addr),
                                  i_mem_ce && i_mem_wr && (i_mem_rd_addr == i_de_rs2_addr),
                                  i_wb_we && (i_wb_rd_addr == i_de_rs2_addr));

    assign alu_load = i_alu_ce && i_alu_is_load;
    assign haz_rs1  = i_de_rs1_used && (i_de_rs1_addr != '0) &&
                      (sb_hit1 || (alu_load && i_alu_rd_addr == i_de_rs1_addr));
    assign haz_rs2  = i_de_rs2_used && (i_de_rs2_addr != '0) &&
                      (sb_hit2 || (alu_load && i_alu_rd_addr == i_de_rs2_addr));
    assign hazard   = i_de_ce && (haz_rs1 || haz_rs2);

    // Next-state: a redirect overrides any stall or watchdog decision.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timeout_d     = timeout_q;
        sb_clear_all  = 1'b0;
        o_force_stall = 1'b0;
        if (i_alu_change_pc) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES);
        end else begin
            case (state_q)
                ST_RUN: begin
                    o_force_stall = hazard;
                    if (hazard) begin
                        state_d = ST_LOAD_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_LOAD_WAIT: begin
                    o_force_stall = hazard;
                    if (!hazard) begin
                        state_d = ST_RUN;
                    end else if (cnt_q == CNT_W'(LOAD_TIMEOUT)) begin
                        timeout_d    = 1'b1;
                        sb_clear_all = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q <= CNT_W'(1)) state_d = ST_RUN;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_flush        = (state_q == ST_FLUSH);
    assign o_state        = state_q;
    assign o_load_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (o_force_stall && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (i_alu_change_pc && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign o_stall_cycles = stall_cnt_q;
    assign o_flush_events = flush_cnt_q;
`else
    assign o_stall_cycles = 32'd0;
    assign o_flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed self-checking bench for hazard_scheduler (FLUSH_CYCLES=2, LOAD_TIMEOUT=15).
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_de_ce;
    logic [4:0]  i_de_rs1_addr, i_de_rs2_addr;
    logic        i_de_rs1_used, i_de_rs2_used;
    logic        i_alu_ce;
    logic [4:0]  i_alu_rd_addr;
    logic        i_alu_wr, i_alu_is_load, i_alu_change_pc;
    logic        i_mem_ce;
    logic [4:0]  i_mem_rd_addr;
    logic        i_mem_wr, i_mem_load_done;
    logic [4:0]  i_mem_load_rd;
    logic        i_wb_we;
    logic [4:0]  i_wb_rd_addr;
    logic        o_force_stall, o_flush, o_load_timeout;
    logic [1:0]  o_fwd_rs1, o_fwd_rs2, o_state;
    logic [31:0] o_stall_cycles, o_flush_events;

    int checks   = 0;
    int failures = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    hazard_scheduler #(.FLUSH_CYCLES(2), .LOAD_TIMEOUT(15)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_de_ce         (i_de_ce),
        .i_de_rs1_addr   (i_de_rs1_addr),
        .i_de_rs2_addr   (i_de_rs2_addr),
        .i_de_rs1_used   (i_de_rs1_used),
        .i_de_rs2_used   (i_de_rs2_used),
        .i_alu_ce        (i_alu_ce),
        .i_alu_rd_addr   (i_alu_rd_addr),
        .i_alu_wr        (i_alu_wr),
        .i_alu_is_load   (i_alu_is_load),
        .i_alu_change_pc (i_alu_change_pc),
        .i_mem_ce        (i_mem_ce),
        .i_mem_rd_addr   (i_mem_rd_addr),
        .i_mem_wr        (i_mem_wr),
        .i_mem_load_done (i_mem_load_done),
        .i_mem_load_rd   (i_mem_load_rd),
        .i_wb_we         (i_wb_we),
        .i_wb_rd_addr    (i_wb_rd_addr),
        .o_force_stall   (o_force_stall),
        .o_flush         (o_flush),
        .o_fwd_rs1       (o_fwd_rs1),
        .o_fwd_rs2       (o_fwd_rs2),
        .o_state         (o_state),
        .o_load_timeout  (o_load_timeout),
        .o_stall_cycles  (o_stall_cycles),
        .o_flush_events  (o_flush_events)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        i_de_ce = 1'b0; i_de_rs1_addr = '0; i_de_rs2_addr = '0;
        i_de_rs1_used = 1'b0; i_de_rs2_used = 1'b0;
        i_alu_ce = 1'b0; i_alu_rd_addr = '0; i_alu_wr = 1'b0;
        i_alu_is_load = 1'b0; i_alu_change_pc = 1'b0;
        i_mem_ce = 1'b0; i_mem_rd_addr = '0; i_mem_wr = 1'b0;
        i_mem_load_done = 1'b0; i_mem_load_rd = '0;
        i_wb_we = 1'b0; i_wb_rd_addr = '0;
    endtask

    // Next cycle: inputs change on the falling edge, outputs sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    task automatic alu_load(input logic [4:0] rd);
        i_alu_ce = 1'b1; i_alu_is_load = 1'b1; i_alu_wr = 1'b1; i_alu_rd_addr = rd;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_state",   32'(o_state), 32'd0);
        check("rst_flush",   32'(o_flush), 32'd0);
        check("rst_stall",   32'(o_force_stall), 32'd0);
        check("rst_fwd1",    32'(o_fwd_rs1), 32'd0);
        check("rst_fwd2",    32'(o_fwd_rs2), 32'd0);
        check("rst_timeout", 32'(o_load_timeout), 32'd0);
        check("rst_stallcnt", o_stall_cycles, 32'd0);
        check("rst_flushcnt", o_flush_events, 32'd0);

        // Forwarding priority, rs = x5 matched in every stage
        next_cycle();
        i_de_ce = 1'b1; i_de_rs1_addr = 5'd5; i_de_rs1_used = 1'b1;
        i_alu_ce = 1'b1; i_alu_wr = 1'b1; i_alu_rd_addr = 5'd5;
        i_mem_ce = 1'b1; i_mem_wr = 1'b1; i_mem_rd_addr = 5'd5;
        i_wb_we = 1'b1; i_wb_rd_addr = 5'd5;
        #1;
        check("fwd_alu", 32'(o_fwd_rs1), 32'd1);
        check("fwd_nostall", 32'(o_force_stall), 32'd0);
        i_de_rs1_addr = 5'd0; i_alu_rd_addr = 5'd0; i_mem_rd_addr = 5'd0; i_wb_rd_addr = 5'd0;
        #1;
        check("fwd_x0", 32'(o_fwd_rs1), 32'd0);
        i_de_rs1_addr = 5'd5; i_alu_rd_addr = 5'd5; i_mem_rd_addr = 5'd5; i_wb_rd_addr = 5'd5;
        i_alu_ce = 1'b0;
        #1;
        check("fwd_mem", 32'(o_fwd_rs1), 32'd2);
        i_mem_ce = 1'b0;
        #1;
        check("fwd_wb", 32'(o_fwd_rs1), 32'd3);
        i_de_rs1_used = 1'b0;
        #1;
        check("fwd_unused", 32'(o_fwd_rs1), 32'd0);
        i_de_rs2_addr = 5'd5; i_de_rs2_used = 1'b1; i_wb_we = 1'b0;
        i_mem_ce = 1'b1;
        #1;
        check("fwd2_mem", 32'(o_fwd_rs2), 32'd2);
        // ALU-stage load never forwards; decode not valid so no stall
        next_cycle();
        alu_load(5'd5);
        i_de_rs2_addr = 5'd5; i_de_rs2_used = 1'b1;
        i_mem_ce = 1'b1; i_mem_wr = 1'b1; i_mem_rd_addr = 5'd5;
        #1;
        check("fwd_skip_load", 32'(o_fwd_rs2), 32'd2);
        check("fwd_load_nostall", 32'(o_force_stall), 32'd0);
        next_cycle();
        i_mem_load_done = 1'b1; i_mem_load_rd = 5'd5;
        next_cycle();
        #1;
        check("fwd_state", 32'(o_state), 32'd0);
        check("fwd_stallcnt", o_stall_cycles, 32'd0);

        // Load-use on x7 via rs2: stalls 4 cycles, released by load_done
        next_cycle();
        alu_load(5'd7);
        i_de_ce = 1'b1; i_de_rs2_addr = 5'd7; i_de_rs2_used = 1'b1;
        #1;
        check("lu_stall0", 32'(o_force_stall), 32'd1);
        check("lu_state0", 32'(o_state), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            i_de_ce = 1'b1; i_de_rs2_addr = 5'd7; i_de_rs2_used = 1'b1;
            #1;
            check($sformatf("lu_stall%0d", i), 32'(o_force_stall), 32'd1);
            check($sformatf("lu_state%0d", i), 32'(o_state), 32'd1);
        end
        next_cycle();
        i_de_ce = 1'b1; i_de_rs2_addr = 5'd7; i_de_rs2_used = 1'b1;
        i_mem_load_done = 1'b1; i_mem_load_rd = 5'd7;
        #1;
        check("lu_release", 32'(o_force_stall), 32'd0);
        next_cycle();
        #1;
        check("lu_state_run", 32'(o_state), 32'd0);
        check("lu_stallcnt", o_stall_cycles, PERF ? 32'd4 : 32'd0);

        // Redirect pulse: flush for exactly two cycles
        next_cycle();
        i_alu_change_pc = 1'b1;
        #1;
        check("fl_pre", 32'(o_flush), 32'd0);
        for (int i = 1; i <= 2; i++) begin
            next_cycle();
            #1;
            check($sformatf("fl_flush%0d", i), 32'(o_flush), 32'd1);
            check($sformatf("fl_state%0d", i), 32'(o_state), 32'd2);
        end
        next_cycle();
        #1;
        check("fl_done", 32'(o_flush), 32'd0);
        check("fl_state_run", 32'(o_state), 32'd0);
        check("fl_eventcnt", o_flush_events, PERF ? 32'd1 : 32'd0);
        check("fl_stallcnt", o_stall_cycles, PERF ? 32'd4 : 32'd0);

        // Redirect while in LOAD_WAIT; scoreboard keeps x7 pending
        next_cycle();
        alu_load(5'd7);
        i_de_ce = 1'b1; i_de_rs1_addr = 5'd7; i_de_rs1_used = 1'b1;
        #1;
        check("rw_stall0", 32'(o_force_stall), 32'd1);
        next_cycle();
        i_de_ce = 1'b1; i_de_rs1_addr = 5'd7; i_de_rs1_used = 1'b1;
        #1;
        check("rw_state_lw", 32'(o_state), 32'd1);
        next_cycle();
        i_de_ce = 1'b1; i_de_rs1_addr = 5'd7; i_de_rs1_used = 1'b1;
        i_alu_change_pc = 1'b1;
        #1;
        check("rw_stall_drop", 32'(o_force_stall), 32'd0);
        next_cycle();
        #1;
        check("rw_state_flush", 32'(o_state), 32'd2);
        check("rw_flush", 32'(o_flush), 32'd1);
        next_cycle();
        next_cycle();
        i_de_ce = 1'b1; i_de_rs1_addr = 5'd7; i_de_rs1_used = 1'b1;
        #1;
        check("rw_run", 32'(o_state), 32'd0);
        check("rw_still_pending", 32'(o_force_stall), 32'd1);
        next_cycle();
        i_de_ce = 1'b1; i_de_rs1_addr = 5'd7; i_de_rs1_used = 1'b1;
        i_mem_load_done = 1'b1; i_mem_load_rd = 5'd7;
        #1;
        check("rw_release", 32'(o_force_stall), 32'd0);
        next_cycle();
        i_de_ce = 1'b1; i_de_rs1_addr = 5'd7; i_de_rs1_used = 1'b1;
        #1;
        check("rw_cleared", 32'(o_force_stall), 32'd0);
        check("rw_state_end", 32'(o_state), 32'd0);

        // Load to x9 never returns: watchdog after 15 LOAD_WAIT cycles
        next_cycle();
        alu_load(5'd9);
        i_de_ce = 1'b1; i_de_rs1_addr = 5'd9; i_de_rs1_used = 1'b1;
        #1;
        check("to_stall0", 32'(o_force_stall), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            next_cycle();
            i_de_ce = 1'b1; i_de_rs1_addr = 5'd9; i_de_rs1_used = 1'b1;
            #1;
            check($sformatf("to_stall%0d", i), 32'(o_force_stall), 32'd1);
            check($sformatf("to_state%0d", i), 32'(o_state), 32'd1);
            check($sformatf("to_flag%0d", i), 32'(o_load_timeout), 32'd0);
        end
        next_cycle();
        i_de_ce = 1'b1; i_de_rs1_addr = 5'd9; i_de_rs1_used = 1'b1;
        #1;
        check("to_flag", 32'(o_load_timeout), 32'd1);
        check("to_state_run", 32'(o_state), 32'd0);
        check("to_sb_cleared", 32'(o_force_stall), 32'd0);
        next_cycle();
        #1;
        check("to_sticky", 32'(o_load_timeout), 32'd1);
        check("to_stallcnt", o_stall_cycles, PERF ? 32'd23 : 32'd0);
        check("to_eventcnt", o_flush_events, PERF ? 32'd2 : 32'd0);

        // Reset mid-operation forgets a pending load and the watchdog flag
        next_cycle();
        alu_load(5'd11);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        i_de_ce = 1'b1; i_de_rs1_addr = 5'd11; i_de_rs1_used = 1'b1;
        #1;
        check("rr_timeout", 32'(o_load_timeout), 32'd0);
        check("rr_state", 32'(o_state), 32'd0);
        check("rr_forgotten", 32'(o_force_stall), 32'd0);
        check("rr_stallcnt", o_stall_cycles, 32'd0);
        check("rr_eventcnt", o_flush_events, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
